// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the round-robin memory-port arbiter.
// rr_pick is written for up to MAX_REQ requesters; callers zero-extend.
package mem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_e;

   localparam int unsigned DEF_ADDR_W = 8;
   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned MAX_REQ    = 8;

   // First set bit at or above ptr; if none, fall back to the lowest set bit (wrap).
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr);
      logic [MAX_REQ-1:0] masked;
      logic [2:0]         w_all;
      logic [2:0]         w_msk;
      masked = '0;
      w_all  = '0;
      w_msk  = '0;
      for (int unsigned i = 0; i < MAX_REQ; i++) begin
         if (i >= 32'(ptr)) masked[i] = req[i];
      end
      for (int unsigned i = MAX_REQ; i > 0; i--) begin
         if (req[i-1])    w_all = 3'(i - 1);
         if (masked[i-1]) w_msk = 3'(i - 1);
      end
      return (masked != '0) ? w_msk : w_all;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter_pick.sv
// Combinational round-robin winner search; the pointer register lives in the parent.
module rr_pick_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [PTR_W-1:0]   winner,
   output logic               any_req
);

   logic [MAX_REQ-1:0] req_ext;

   always_comb begin
      req_ext              = '0;
      req_ext[NUM_REQ-1:0] = req;
      winner               = PTR_W'(rr_pick(req_ext, 3'(ptr)));
      any_req              = |req;
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin sequencer sharing one synchronous memory port between NUM_REQ clients.
// Every output is a flop; the comb block computes their next values.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_W     = DEF_ADDR_W,
   parameter int unsigned DATA_W     = DEF_DATA_W,
   parameter int unsigned RD_LATENCY = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_read,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_enable,
   output logic                      mem_read,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(RD_LATENCY + 1);

   if (RD_LATENCY < 1) begin : g_lat_check
      $error("mem_rr_arbiter: RD_LATENCY must be at least 1");
   end
   if (NUM_REQ < 2 || NUM_REQ > MAX_REQ) begin : g_req_check
      $error("mem_rr_arbiter: NUM_REQ must be in 2..8");
   end

   arb_state_e         state, state_d;
   logic [PTR_W-1:0]   ptr, ptr_d;
   logic [PTR_W-1:0]   win, win_d;
   logic [PTR_W-1:0]   pick;
   logic               any_req;
   logic [CNT_W-1:0]   cnt, cnt_d;
   logic [NUM_REQ-1:0] gnt_d, rsp_valid_d;
   logic [DATA_W-1:0]  rsp_rdata_d, mem_wdata_d;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic               mem_enable_d, mem_read_d;

   rr_pick_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req     (req),
      .ptr     (ptr),
      .winner  (pick),
      .any_req (any_req)
   );

   // The mem_* output flops double as the command latches, so ISSUE just replays them.
   always_comb begin
      state_d      = state;
      ptr_d        = ptr;
      win_d        = win;
      cnt_d        = cnt;
      gnt_d        = '0;
      rsp_valid_d  = '0;
      rsp_rdata_d  = rsp_rdata;
      mem_enable_d = 1'b0;
      mem_read_d   = mem_read;
      mem_addr_d   = mem_addr;
      mem_wdata_d  = mem_wdata;
      case (state)
         IDLE: begin
            if (any_req) begin
               win_d        = pick;
               mem_read_d   = req_read[pick];
               mem_addr_d   = req_addr[pick*ADDR_W +: ADDR_W];
               mem_wdata_d  = req_wdata[pick*DATA_W +: DATA_W];
               gnt_d[pick]  = 1'b1;
               mem_enable_d = 1'b1;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            if (mem_read) begin
               cnt_d   = CNT_W'(RD_LATENCY);
               state_d = WAIT;
            end else begin
               rsp_rdata_d      = '0;
               rsp_valid_d[win] = 1'b1;
               state_d          = DONE;
            end
         end
         WAIT: begin
            cnt_d = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               rsp_rdata_d      = mem_rdata;
               rsp_valid_d[win] = 1'b1;
               state_d          = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         ptr        <= '0;
         win        <= '0;
         cnt        <= '0;
         gnt        <= '0;
         rsp_valid  <= '0;
         rsp_rdata  <= '0;
         mem_enable <= 1'b0;
         mem_read   <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_d;
         ptr        <= ptr_d;
         win        <= win_d;
         cnt        <= cnt_d;
         gnt        <= gnt_d;
         rsp_valid  <= rsp_valid_d;
         rsp_rdata  <= rsp_rdata_d;
         mem_enable <= mem_enable_d;
         mem_read   <= mem_read_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
      end
   end

endmodule
